// File: rtl/message_combiner.sv
// Packs runs of N_SLICES narrow words into one wide word, buffers them in a FIFO
// and presents them downstream with a toggling new-data flag.
module message_combiner #(
    parameter int N_SLICES          = 2,
    parameter int WIDTH             = 33,
    parameter int BUFFER_LENGTH     = 16,
    parameter int LOG_BUFFER_LENGTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_nd,
    input  logic                        out_ready,
    output logic [WIDTH*N_SLICES-1:0]   out_data,
    output logic                        out_nd,
    output logic                        error
);

    localparam int CW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam int WW = WIDTH * N_SLICES;

    // Slot 0 is never stored: the final word goes straight into the FIFO.
    logic [N_SLICES-1:1][WIDTH-1:0] asm_q;
    logic [CW-1:0]                  slice_cnt;

    logic [WW-1:0]                  mem [BUFFER_LENGTH];
    logic [LOG_BUFFER_LENGTH-1:0]   wr_ptr;
    logic [LOG_BUFFER_LENGTH-1:0]   rd_ptr;
    logic [LOG_BUFFER_LENGTH:0]     count;

    logic          last_slice;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic [WW-1:0] push_word;

    assign last_slice = (slice_cnt == CW'(N_SLICES - 1));
    assign push       = in_nd && last_slice;
    assign full       = (count == (LOG_BUFFER_LENGTH + 1)'(BUFFER_LENGTH));
    assign pop        = (count != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok    = push && (!full || pop);
    assign push_word  = {asm_q, in_data};

    // First word of a group lands in the top slice.
    for (genvar s = 1; s < N_SLICES; s++) begin : g_slot
        always_ff @(posedge clk) begin
            if (in_nd && slice_cnt == CW'(N_SLICES - 1 - s))
                asm_q[s] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            slice_cnt <= '0;
        else if (in_nd)
            slice_cnt <= last_slice ? '0 : slice_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
            out_nd   <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_data <= mem[rd_ptr];
                out_nd   <= ~out_nd;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_message_combiner.sv
// Scoreboarded bench: a queue-based reference model predicts emitted wide words,
// toggle timing and the sticky error; a monitor compares after every edge.
module tb_message_combiner;

    localparam int N  = 2;
    localparam int W  = 33;
    localparam int BL = 16;
    localparam int WW = W * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_nd = 1'b0;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic          out_nd;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] sb[$];     // words the DUT should emit, in order
    logic [WW-1:0] fifo_m[$]; // model FIFO contents
    logic [W-1:0]  part[$];   // model partial group
    bit            exp_pop = 1'b0;
    bit            exp_err = 1'b0;

    message_combiner #(.N_SLICES(N), .WIDTH(W), .BUFFER_LENGTH(BL), .LOG_BUFFER_LENGTH(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd),
        .out_ready(out_ready), .out_data(out_data), .out_nd(out_nd), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model predicts the effect of the coming edge.
    task automatic step(input bit nd, input logic [W-1:0] d, input bit rdy, input bit r = 1'b0);
        logic [WW-1:0] word;
        bit            was_full;
        @(negedge clk);
        in_nd = nd; in_data = d; out_ready = rdy; rst = r;
        if (r) begin
            fifo_m.delete(); part.delete();
            exp_pop = 1'b0; exp_err = 1'b0;
            return;
        end
        was_full = (fifo_m.size() == BL);
        exp_pop  = (fifo_m.size() > 0) && rdy;
        if (exp_pop) sb.push_back(fifo_m.pop_front());
        if (nd) begin
            part.push_back(d);
            if (part.size() == N) begin
                word = '0;
                foreach (part[i]) word = (word << W) | WW'(part[i]);
                part.delete();
                if (was_full && !exp_pop) exp_err = 1'b1;
                else fifo_m.push_back(word);
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: checks toggle timing, data order and the error flag after each edge.
    initial begin : monitor
        bit            prev_nd;
        bit            r, ep, ee, tog;
        prev_nd = 1'b0;
        forever begin
            @(posedge clk);
            r = rst; ep = exp_pop; ee = exp_err;
            #1;
            if (r) begin
                chk("reset out_data", out_data, '0);
                chk("reset out_nd", WW'(out_nd), '0);
                chk("reset error", WW'(error), '0);
                prev_nd = 1'b0;
            end else begin
                tog = (out_nd != prev_nd);
                chk("out_nd toggle", WW'(tog), WW'(ep));
                if (tog) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected word: got %h expected none", out_data);
                    end else begin
                        chk("out_data", out_data, sb.pop_front());
                    end
                end
                chk("error", WW'(error), WW'(ee));
                prev_nd = out_nd;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        do_reset();

        // basic pack
        step(1'b1, 33'h1, 1'b1);
        step(1'b1, 33'h2, 1'b1);
        idle(3, 1'b1);

        // back-to-back 1..8
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1);
        idle(3, 1'b1);

        // fill to exactly full with backpressure, then drain
        for (int i = 0; i < 32; i++) step(1'b1, W'(32'h100 + i), 1'b0);
        idle(2, 1'b0);
        idle(20, 1'b1);

        // overflow: 17th pair dropped
        for (int i = 0; i < 34; i++) step(1'b1, W'(32'h200 + i), 1'b0);
        idle(2, 1'b0);
        idle(20, 1'b1);
        do_reset();

        // full with simultaneous pop on the completing slice
        for (int i = 0; i < 32; i++) step(1'b1, W'(32'h300 + i), 1'b0);
        step(1'b1, 33'h1_0000_0033, 1'b0);
        step(1'b1, 33'h1_0000_0034, 1'b1);
        idle(20, 1'b1);

        // reset mid-group
        step(1'b1, 33'hA, 1'b1);
        do_reset();
        step(1'b1, 33'hB, 1'b1);
        step(1'b1, 33'hC, 1'b1);
        idle(3, 1'b1);

        // reset with words queued: nothing may emerge afterwards
        for (int i = 0; i < 10; i++) step(1'b1, W'(32'h400 + i), 1'b0);
        do_reset();
        idle(5, 1'b1);

        // randomized traffic, occasionally overflowing
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 9) < 7), {1'($urandom), 32'($urandom)},
                 ($urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 5 : 2)));
            if (i % 300 == 299) do_reset();
        end
        idle(40, 1'b1);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d words pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
